// File: rtl/alu_arbiter_if.sv
// Bus bundle between the alu_arbiter and its two requesters plus the shared ALU.
// slave is the arbiter's view; master is the collective view of requesters and ALU.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_srcA;
  logic [31:0] req0_srcB;
  logic [2:0]  req0_aluOp;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_srcA;
  logic [31:0] req1_srcB;
  logic [2:0]  req1_aluOp;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [31:0] alu_srcA;
  logic [31:0] alu_srcB;
  logic [2:0]  alu_aluOp;
  logic [31:0] alu_result;
  logic        alu_zero;

  modport slave (
    input  req0_valid, req0_srcA, req0_srcB, req0_aluOp,
    input  req1_valid, req1_srcA, req1_srcB, req1_aluOp,
    input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero, alu_srcA, alu_srcB, alu_aluOp
  );

  modport master (
    output req0_valid, req0_srcA, req0_srcB, req0_aluOp,
    output req1_valid, req1_srcA, req1_srcB, req1_aluOp,
    output rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero, alu_srcA, alu_srcB, alu_aluOp
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for the shared ALU with a one-entry tagged response buffer.
// Round-robin or fixed-priority grant; accept and drain may happen in the same cycle.
module alu_arbiter #(
  parameter bit         FIXED_PRIO = 1'b0,
  parameter logic [2:0] ALU_OP_ADD = 3'b000
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        ptr_q, ptr_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        drain, can_accept, gnt_any, gnt_id, accept;

  always_comb begin
    drain      = (state_q == FULL) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
    can_accept = (state_q == EMPTY) || drain;
  end

  // Fixed mode always has a grant target (req1 whenever req0 is idle); round-robin only grants a valid requester.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (can_accept) begin
      if (FIXED_PRIO) begin
        gnt_any = 1'b1;
        gnt_id  = !bus.req0_valid;
      end else if (ptr_q ? bus.req1_valid : bus.req0_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ptr_q;
      end else if (ptr_q ? bus.req0_valid : bus.req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~ptr_q;
      end
    end
    accept = gnt_any && (gnt_id ? bus.req1_valid : bus.req0_valid);
  end

  always_comb begin
    bus.req0_ready = gnt_any && !gnt_id;
    bus.req1_ready = gnt_any && gnt_id;
    bus.alu_srcA   = '0;
    bus.alu_srcB   = '0;
    bus.alu_aluOp  = ALU_OP_ADD;
    if (gnt_any) begin
      bus.alu_srcA  = gnt_id ? bus.req1_srcA  : bus.req0_srcA;
      bus.alu_srcB  = gnt_id ? bus.req1_srcB  : bus.req0_srcB;
      bus.alu_aluOp = gnt_id ? bus.req1_aluOp : bus.req0_aluOp;
    end
  end

  always_comb begin
    bus.rsp0_valid = (state_q == FULL) && !owner_q;
    bus.rsp1_valid = (state_q == FULL) && owner_q;
    bus.rsp_result = result_q;
    bus.rsp_zero   = zero_q;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (accept) begin
      state_d  = FULL;
      owner_d  = gnt_id;
      result_d = bus.alu_result;
      zero_d   = bus.alu_zero;
      ptr_d    = FIXED_PRIO ? 1'b0 : ~gnt_id;
    end else if (drain) begin
      state_d  = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a behavioural model.
// Two instances: round-robin (bus_rr) and fixed-priority (bus_fp), each with its own ALU model.
module tb_alu_arbiter;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned n_run = 0;
  int unsigned n_fail = 0;

  // behavioural model of the round-robin instance's buffer
  bit          m_full = 0, m_owner = 0, m_ptr = 0, m_zero = 0;
  logic [31:0] m_res = '0;

  alu_arbiter_if bus_rr();
  alu_arbiter_if bus_fp();

  alu_arbiter #(.FIXED_PRIO(1'b0), .ALU_OP_ADD(OP_ADD)) dut_rr (.clk(clk), .reset(reset), .bus(bus_rr.slave));
  alu_arbiter #(.FIXED_PRIO(1'b1), .ALU_OP_ADD(OP_ADD)) dut_fp (.clk(clk), .reset(reset), .bus(bus_fp.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return {31'b0, ($signed(a) < $signed(b))};
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  assign bus_rr.alu_result = alu_f(bus_rr.alu_aluOp, bus_rr.alu_srcA, bus_rr.alu_srcB);
  assign bus_rr.alu_zero   = (alu_f(bus_rr.alu_aluOp, bus_rr.alu_srcA, bus_rr.alu_srcB) == 32'd0);
  assign bus_fp.alu_result = alu_f(bus_fp.alu_aluOp, bus_fp.alu_srcA, bus_fp.alu_srcB);
  assign bus_fp.alu_zero   = (alu_f(bus_fp.alu_aluOp, bus_fp.alu_srcA, bus_fp.alu_srcB) == 32'd0);

  // Round-robin rule: the preferred requester wins if valid, else the other one if valid.
  function automatic int rr_winner();
    logic [1:0] v;
    int pref;
    v = {bus_rr.req1_valid, bus_rr.req0_valid};
    pref = m_ptr ? 1 : 0;
    if (!m_full || (m_owner ? bus_rr.rsp1_ready : bus_rr.rsp0_ready)) begin
      if (v[pref]) return pref;
      if (v[1 - pref]) return 1 - pref;
    end
    return -1;
  endfunction

  task automatic step();
    int w;
    bit drain, rst;
    logic [31:0] a, b;
    logic [2:0] op;
    rst = reset;
    w = rr_winner();
    drain = m_full && (m_owner ? bus_rr.rsp1_ready : bus_rr.rsp0_ready);
    a = (w == 1) ? bus_rr.req1_srcA : bus_rr.req0_srcA;
    b = (w == 1) ? bus_rr.req1_srcB : bus_rr.req0_srcB;
    op = (w == 1) ? bus_rr.req1_aluOp : bus_rr.req0_aluOp;
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_owner = 0; m_ptr = 0; m_res = '0; m_zero = 0;
    end else if (w >= 0) begin
      m_res = alu_f(op, a, b); m_zero = (m_res == 0); m_owner = (w == 1); m_full = 1; m_ptr = (w == 0);
    end else if (drain) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic idle_all();
    bus_rr.req0_valid = 0; bus_rr.req1_valid = 0; bus_rr.rsp0_ready = 0; bus_rr.rsp1_ready = 0;
    bus_fp.req0_valid = 0; bus_fp.req1_valid = 0; bus_fp.rsp0_ready = 0; bus_fp.rsp1_ready = 0;
    bus_rr.req0_srcA = '0; bus_rr.req0_srcB = '0; bus_rr.req0_aluOp = OP_ADD;
    bus_rr.req1_srcA = '0; bus_rr.req1_srcB = '0; bus_rr.req1_aluOp = OP_ADD;
    bus_fp.req0_srcA = '0; bus_fp.req0_srcB = '0; bus_fp.req0_aluOp = OP_ADD;
    bus_fp.req1_srcA = '0; bus_fp.req1_srcB = '0; bus_fp.req1_aluOp = OP_ADD;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    n_run++; if (bus_rr.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp0_valid: got %b want 0", bus_rr.rsp0_valid); end
    n_run++; if (bus_rr.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp1_valid: got %b want 0", bus_rr.rsp1_valid); end
    n_run++; if (bus_rr.rsp_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %0h want 0", bus_rr.rsp_result); end
    n_run++; if (bus_rr.rsp_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", bus_rr.rsp_zero); end
    n_run++; if (bus_fp.rsp0_valid !== 1'b0 || bus_fp.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fp_valid: got %b%b want 00", bus_fp.rsp1_valid, bus_fp.rsp0_valid); end
    n_run++; if (bus_rr.alu_aluOp !== OP_ADD || bus_rr.alu_srcA !== 32'd0) begin n_fail++; $display("FAIL idle_alu: got op %0d a %0h want op 0 a 0", bus_rr.alu_aluOp, bus_rr.alu_srcA); end
  endtask

  task automatic test_single();
    bus_rr.req0_valid = 1; bus_rr.req0_aluOp = OP_ADD; bus_rr.req0_srcA = 32'd5; bus_rr.req0_srcB = 32'd3; bus_rr.rsp0_ready = 1;
    #1;
    n_run++; if (bus_rr.req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", bus_rr.req0_ready); end
    n_run++; if (bus_rr.alu_srcA !== 32'd5 || bus_rr.alu_srcB !== 32'd3) begin n_fail++; $display("FAIL single_alu_ops: got %0h,%0h want 5,3", bus_rr.alu_srcA, bus_rr.alu_srcB); end
    step();
    bus_rr.req0_valid = 0;
    #1;
    n_run++; if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_valid: got %b%b want 01", bus_rr.rsp1_valid, bus_rr.rsp0_valid); end
    n_run++; if (bus_rr.rsp_result !== 32'd8 || bus_rr.rsp_zero !== 1'b0) begin n_fail++; $display("FAIL single_result: got %0h/%b want 8/0", bus_rr.rsp_result, bus_rr.rsp_zero); end
    step();
    #1;
    n_run++; if (bus_rr.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", bus_rr.rsp0_valid); end
  endtask

  task automatic test_rr_alternation();
    do_reset();
    bus_rr.rsp0_ready = 1; bus_rr.rsp1_ready = 1;
    bus_rr.req0_valid = 1; bus_rr.req0_aluOp = OP_SUB; bus_rr.req0_srcA = 32'd7; bus_rr.req0_srcB = 32'd7;
    bus_rr.req1_valid = 1; bus_rr.req1_aluOp = OP_OR; bus_rr.req1_srcA = 32'hF0; bus_rr.req1_srcB = 32'h0F;
    #1;
    n_run++; if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b0) begin n_fail++; $display("FAIL rr_first_grant: got r1r0=%b%b want 01", bus_rr.req1_ready, bus_rr.req0_ready); end
    step();
    bus_rr.req0_valid = 0;
    #1;
    n_run++; if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp_result !== 32'd0 || bus_rr.rsp_zero !== 1'b1) begin n_fail++; $display("FAIL rr_first_rsp: got v%b %0h/%b want v1 0/1", bus_rr.rsp0_valid, bus_rr.rsp_result, bus_rr.rsp_zero); end
    n_run++; if (bus_rr.req1_ready !== 1'b1) begin n_fail++; $display("FAIL rr_back_to_back: got %b want 1", bus_rr.req1_ready); end
    step();
    bus_rr.req1_valid = 0;
    #1;
    n_run++; if (bus_rr.rsp1_valid !== 1'b1 || bus_rr.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rr_second_owner: got %b%b want 10", bus_rr.rsp1_valid, bus_rr.rsp0_valid); end
    n_run++; if (bus_rr.rsp_result !== 32'hFF || bus_rr.rsp_zero !== 1'b0) begin n_fail++; $display("FAIL rr_second_rsp: got %0h/%b want ff/0", bus_rr.rsp_result, bus_rr.rsp_zero); end
    step();
  endtask

  task automatic test_backpressure();
    bus_rr.rsp0_ready = 0; bus_rr.rsp1_ready = 1;
    bus_rr.req0_valid = 1; bus_rr.req0_aluOp = OP_ADD; bus_rr.req0_srcA = 32'd1; bus_rr.req0_srcB = 32'd2;
    step();
    bus_rr.req0_valid = 0;
    bus_rr.req1_valid = 1; bus_rr.req1_aluOp = OP_ADD; bus_rr.req1_srcA = 32'd10; bus_rr.req1_srcB = 32'd20;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      n_run++; if (bus_rr.req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", i, bus_rr.req1_ready); end
      n_run++; if (bus_rr.rsp_result !== 32'd3 || bus_rr.rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b %0h want v1 3", i, bus_rr.rsp0_valid, bus_rr.rsp_result); end
      step();
    end
    bus_rr.rsp0_ready = 1;
    #1;
    n_run++; if (bus_rr.req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus_rr.req1_ready); end
    step();
    bus_rr.req1_valid = 0;
    #1;
    n_run++; if (bus_rr.rsp1_valid !== 1'b1 || bus_rr.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL bp_owner: got %b%b want 10", bus_rr.rsp1_valid, bus_rr.rsp0_valid); end
    n_run++; if (bus_rr.rsp_result !== 32'd30) begin n_fail++; $display("FAIL bp_result: got %0h want 1e", bus_rr.rsp_result); end
    step();
    bus_rr.rsp0_ready = 0; bus_rr.rsp1_ready = 0;
  endtask

  task automatic test_fixed_prio();
    bus_fp.rsp0_ready = 1; bus_fp.rsp1_ready = 1;
    bus_fp.req0_valid = 1; bus_fp.req0_aluOp = OP_SLL; bus_fp.req0_srcA = 32'd1; bus_fp.req0_srcB = 32'd4;
    bus_fp.req1_valid = 1; bus_fp.req1_aluOp = OP_ADD; bus_fp.req1_srcA = 32'd2; bus_fp.req1_srcB = 32'd2;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      n_run++; if (bus_fp.req0_ready !== 1'b1 || bus_fp.req1_ready !== 1'b0) begin n_fail++; $display("FAIL fp_grant[%0d]: got r1r0=%b%b want 01", i, bus_fp.req1_ready, bus_fp.req0_ready); end
      step();
      n_run++; if (bus_fp.rsp0_valid !== 1'b1 || bus_fp.rsp_result !== 32'd16) begin n_fail++; $display("FAIL fp_rsp[%0d]: got v%b %0h want v1 10", i, bus_fp.rsp0_valid, bus_fp.rsp_result); end
    end
    bus_fp.req0_valid = 0;
    #1;
    n_run++; if (bus_fp.req1_ready !== 1'b1) begin n_fail++; $display("FAIL fp_req1_grant: got %b want 1", bus_fp.req1_ready); end
    step();
    bus_fp.req1_valid = 0;
    #1;
    n_run++; if (bus_fp.rsp1_valid !== 1'b1 || bus_fp.rsp_result !== 32'd4) begin n_fail++; $display("FAIL fp_req1_rsp: got v%b %0h want v1 4", bus_fp.rsp1_valid, bus_fp.rsp_result); end
    step();
    bus_fp.rsp0_ready = 0; bus_fp.rsp1_ready = 0;
  endtask

  task automatic test_reset_mid();
    bus_rr.rsp0_ready = 0; bus_rr.rsp1_ready = 0;
    bus_rr.req1_valid = 1; bus_rr.req1_aluOp = OP_XOR; bus_rr.req1_srcA = 32'hA5; bus_rr.req1_srcB = 32'hFF;
    step();
    bus_rr.req1_valid = 0;
    #1;
    n_run++; if (bus_rr.rsp1_valid !== 1'b1 || bus_rr.rsp_result !== 32'h5A) begin n_fail++; $display("FAIL rm_fill: got v%b %0h want v1 5a", bus_rr.rsp1_valid, bus_rr.rsp_result); end
    reset = 1'b1;
    bus_rr.req0_valid = 1; bus_rr.req0_aluOp = OP_ADD; bus_rr.req0_srcA = 32'd9; bus_rr.req0_srcB = 32'd9;
    step();
    reset = 1'b0;
    bus_rr.req1_valid = 1;
    #1;
    n_run++; if (bus_rr.rsp0_valid !== 1'b0 || bus_rr.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b%b want 00", bus_rr.rsp1_valid, bus_rr.rsp0_valid); end
    n_run++; if (bus_rr.rsp_result !== 32'd0 || bus_rr.rsp_zero !== 1'b0) begin n_fail++; $display("FAIL rm_result: got %0h/%b want 0/0", bus_rr.rsp_result, bus_rr.rsp_zero); end
    n_run++; if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b0) begin n_fail++; $display("FAIL rm_regrant: got r1r0=%b%b want 01", bus_rr.req1_ready, bus_rr.req0_ready); end
    step();
    bus_rr.req0_valid = 0; bus_rr.req1_valid = 0; bus_rr.rsp0_ready = 1;
    #1;
    n_run++; if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp_result !== 32'd18) begin n_fail++; $display("FAIL rm_after: got v%b %0h want v1 12", bus_rr.rsp0_valid, bus_rr.rsp_result); end
    step();
  endtask

  function automatic logic [31:0] rand_operand();
    return ($urandom_range(3, 0) == 0) ? 32'($urandom) : 32'($urandom_range(15, 0));
  endfunction

  task automatic test_random();
    int w;
    bit hold0 = 0, hold1 = 0;
    do_reset();
    for (int unsigned c = 0; c < 400; c++) begin
      if (!hold0 && $urandom_range(1, 0) == 1) begin
        bus_rr.req0_valid = 1; bus_rr.req0_aluOp = 3'($urandom_range(7, 0));
        bus_rr.req0_srcA = rand_operand();
        bus_rr.req0_srcB = ($urandom_range(3, 0) == 0) ? bus_rr.req0_srcA : rand_operand();
        hold0 = 1;
      end
      if (!hold1 && $urandom_range(1, 0) == 1) begin
        bus_rr.req1_valid = 1; bus_rr.req1_aluOp = 3'($urandom_range(7, 0));
        bus_rr.req1_srcA = rand_operand();
        bus_rr.req1_srcB = ($urandom_range(3, 0) == 0) ? bus_rr.req1_srcA : rand_operand();
        hold1 = 1;
      end
      bus_rr.rsp0_ready = ($urandom_range(3, 0) != 0);
      bus_rr.rsp1_ready = ($urandom_range(3, 0) != 0);
      #1;
      w = rr_winner();
      n_run++; if (bus_rr.req0_ready !== 1'(w == 0) || bus_rr.req1_ready !== 1'(w == 1)) begin n_fail++; $display("FAIL rand_ready[%0d]: got r1r0=%b%b want %b%b", c, bus_rr.req1_ready, bus_rr.req0_ready, w == 1, w == 0); end
      n_run++; if (bus_rr.rsp0_valid !== 1'(m_full && !m_owner) || bus_rr.rsp1_valid !== 1'(m_full && m_owner)) begin n_fail++; $display("FAIL rand_rsp_valid[%0d]: got %b%b want %b%b", c, bus_rr.rsp1_valid, bus_rr.rsp0_valid, m_full && m_owner, m_full && !m_owner); end
      if (m_full) begin
        n_run++; if (bus_rr.rsp_result !== m_res || bus_rr.rsp_zero !== m_zero) begin n_fail++; $display("FAIL rand_result[%0d]: got %0h/%b want %0h/%b", c, bus_rr.rsp_result, bus_rr.rsp_zero, m_res, m_zero); end
      end
      if (w == 0) begin
        n_run++; if (bus_rr.alu_aluOp !== bus_rr.req0_aluOp || bus_rr.alu_srcA !== bus_rr.req0_srcA || bus_rr.alu_srcB !== bus_rr.req0_srcB) begin n_fail++; $display("FAIL rand_alu0[%0d]: got op %0d %0h,%0h", c, bus_rr.alu_aluOp, bus_rr.alu_srcA, bus_rr.alu_srcB); end
      end else if (w == 1) begin
        n_run++; if (bus_rr.alu_aluOp !== bus_rr.req1_aluOp || bus_rr.alu_srcA !== bus_rr.req1_srcA || bus_rr.alu_srcB !== bus_rr.req1_srcB) begin n_fail++; $display("FAIL rand_alu1[%0d]: got op %0d %0h,%0h", c, bus_rr.alu_aluOp, bus_rr.alu_srcA, bus_rr.alu_srcB); end
      end else begin
        n_run++; if (bus_rr.alu_aluOp !== OP_ADD || bus_rr.alu_srcA !== 32'd0 || bus_rr.alu_srcB !== 32'd0) begin n_fail++; $display("FAIL rand_alu_idle[%0d]: got op %0d %0h,%0h want 0 0,0", c, bus_rr.alu_aluOp, bus_rr.alu_srcA, bus_rr.alu_srcB); end
      end
      step();
      if (w == 0) begin hold0 = 0; bus_rr.req0_valid = 0; end
      if (w == 1) begin hold1 = 0; bus_rr.req1_valid = 0; end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_alternation();
    test_backpressure();
    test_fixed_prio();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
